// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
// Module  : pipeline_stall_ctrl
// Brief   : Per-stage enable/flush control from mem-busy, branch-flush and
//           load-use requests, with memory-wait watchdog and perf counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             branch_flush,
    input  logic             mem_busy,
    input  logic             clr_counters,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int             WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(TIMEOUT);

    typedef enum logic [0:0] {
        S_RUN      = 1'b0,
        S_MEM_WAIT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                pend_q, pend_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                tmo_q, tmo_d;
    logic [CNT_W-1:0]    stall_q, bubble_q, flush_q;

    logic w_pc_en, w_if_id_en, w_if_id_flush, w_id_ex_en, w_id_ex_flush;
    logic w_ex_mem_en, w_mem_wb_en;
    logic w_inc_stall, w_inc_bubble, w_inc_flush;
    logic w_flush;

    // pend_q is only ever set while in MEM_WAIT, so it is harmless in RUN
    assign w_flush = branch_flush | pend_q;

    always_comb begin
        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_en    = 1'b1;
        w_id_ex_flush = 1'b0;
        w_ex_mem_en   = 1'b1;
        w_mem_wb_en   = 1'b1;
        w_inc_stall   = 1'b0;
        w_inc_bubble  = 1'b0;
        w_inc_flush   = 1'b0;
        state_d       = state_q;
        pend_d        = pend_q;
        wait_d        = wait_q;
        tmo_d         = tmo_q;

        if (mem_busy) begin
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_id_ex_en  = 1'b0;
            w_ex_mem_en = 1'b0;
            w_mem_wb_en = 1'b0;
            w_inc_stall = 1'b1;
            if (state_q == S_RUN) begin
                state_d = S_MEM_WAIT;
                pend_d  = branch_flush;
                wait_d  = WAIT_W'(1);
            end else begin
                pend_d = pend_q | branch_flush;
                if (wait_q < C_TIMEOUT) begin
                    wait_d = wait_q + WAIT_W'(1);
                end
                if (wait_d == C_TIMEOUT) begin
                    tmo_d = 1'b1;
                end
            end
        end else begin
            state_d = S_RUN;
            pend_d  = 1'b0;
            wait_d  = '0;
            if (w_flush) begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
                w_inc_flush   = 1'b1;
            end else if (load_use_stall) begin
                w_pc_en       = 1'b0;
                w_if_id_en    = 1'b0;
                w_id_ex_flush = 1'b1;
                w_inc_bubble  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pend_q  <= 1'b0;
            wait_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
        end
    end

    // Counters saturate; clear wins over any same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else if (clr_counters) begin
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            if (w_inc_stall && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (w_inc_bubble && (bubble_q != '1)) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
            if (w_inc_flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    // Hold the whole pipeline frozen and flushed while reset is asserted
    assign pc_en        = rst_n & w_pc_en;
    assign if_id_en     = rst_n & w_if_id_en;
    assign id_ex_en     = rst_n & w_id_ex_en;
    assign ex_mem_en    = rst_n & w_ex_mem_en;
    assign mem_wb_en    = rst_n & w_mem_wb_en;
    assign if_id_flush  = ~rst_n | w_if_id_flush;
    assign id_ex_flush  = ~rst_n | w_id_ex_flush;
    assign mem_timeout  = tmo_q;
    assign stall_cycles = stall_q;
    assign bubble_count = bubble_q;
    assign flush_count  = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_stall_ctrl
// Brief   : Directed bench for pipeline_stall_ctrl with a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_stall_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 16;
    localparam int SAT     = (1 << CNT_W) - 1;

    localparam logic [6:0] C_RST   = 7'b0010100;
    localparam logic [6:0] C_IDLE  = 7'b1101011;
    localparam logic [6:0] C_FLUSH = 7'b1111111;
    localparam logic [6:0] C_LU    = 7'b0001111;
    localparam logic [6:0] C_BUSY  = 7'b0000000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lu = 1'b0, bf = 1'b0, mb = 1'b0, clr = 1'b0;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic mem_timeout;
    logic [CNT_W-1:0] stall_cycles, bubble_count, flush_count;
    logic [6:0] ctrl;

    int n_vec = 0;
    int n_err = 0;

    // Model state: plain integers tracking the rules
    bit m_wait = 0, m_pend = 0, m_tmo = 0;
    int m_wc = 0, m_stall = 0, m_bub = 0, m_fl = 0;

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_use_stall (lu),
        .branch_flush   (bf),
        .mem_busy       (mb),
        .clr_counters   (clr),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_en       (id_ex_en),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .mem_timeout    (mem_timeout),
        .stall_cycles   (stall_cycles),
        .bubble_count   (bubble_count),
        .flush_count    (flush_count)
    );

    assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    function automatic logic [6:0] exp_ctrl();
        if (!rst_n)                     return C_RST;
        if (mb)                         return C_BUSY;
        if (bf || (m_wait && m_pend))   return C_FLUSH;
        if (lu)                         return C_LU;
        return C_IDLE;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait = 0; m_pend = 0; m_tmo = 0; m_wc = 0;
            m_stall = 0; m_bub = 0; m_fl = 0;
        end else begin
            if (mb) begin
                m_stall = sat_inc(m_stall);
                if (!m_wait) begin
                    m_wait = 1; m_pend = bf; m_wc = 1;
                end else begin
                    m_pend = m_pend | bf;
                    if (m_wc < TIMEOUT) m_wc++;
                    if (m_wc == TIMEOUT) m_tmo = 1;
                end
            end else begin
                if (bf || (m_wait && m_pend)) m_fl = sat_inc(m_fl);
                else if (lu)                  m_bub = sat_inc(m_bub);
                m_wait = 0; m_pend = 0; m_wc = 0;
            end
            if (clr) begin
                m_stall = 0; m_bub = 0; m_fl = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("ctrl", 32'(ctrl), 32'(exp_ctrl()));
        check("mem_timeout", 32'(mem_timeout), 32'(m_tmo));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check("bubble_count", 32'(bubble_count), 32'(m_bub));
        check("flush_count", 32'(flush_count), 32'(m_fl));
    end

    task automatic apply(input logic l, input logic b, input logic m, input logic c);
        lu = l; bf = b; mb = m; clr = c;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("lit_rst_ctrl", 32'(ctrl), 32'(C_RST));
        check("lit_rst_bub", 32'(bubble_count), 0);
        rst_n = 1'b1;

        apply(0, 0, 0, 0);
        check("lit_idle_ctrl", 32'(ctrl), 32'(C_IDLE));
        check("lit_idle_tmo", 32'(mem_timeout), 0);
        tick();

        apply(1, 0, 0, 0);
        check("lit_lu_ctrl", 32'(ctrl), 32'(C_LU));
        tick();
        check("lit_lu_bub", 32'(bubble_count), 1);
        apply(0, 0, 0, 0);
        check("lit_after_lu", 32'(ctrl), 32'(C_IDLE));
        tick();

        apply(0, 0, 0, 1); tick();
        apply(1, 1, 0, 0);
        check("lit_flush_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        check("lit_flush_cnt", 32'(flush_count), 1);
        check("lit_flush_bub", 32'(bubble_count), 0);

        apply(0, 0, 0, 1); tick();
        for (int i = 0; i < 4; i++) begin
            apply(0, (i == 1), 1, 0);
            check("lit_wait_ctrl", 32'(ctrl), 32'(C_BUSY));
            tick();
        end
        check("lit_wait_stall", 32'(stall_cycles), 4);
        apply(0, 0, 0, 0);
        check("lit_release_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        check("lit_release_fl", 32'(flush_count), 1);
        apply(0, 0, 0, 0); tick();

        for (int i = 0; i < 15; i++) begin apply(0, 0, 1, 0); tick(); end
        check("lit_tmo15", 32'(mem_timeout), 0);
        apply(0, 0, 0, 0); tick();
        for (int i = 0; i < 16; i++) begin apply(0, 0, 1, 0); tick(); end
        check("lit_tmo16", 32'(mem_timeout), 1);
        apply(0, 0, 0, 0); tick(); tick();
        check("lit_tmo_sticky", 32'(mem_timeout), 1);
        rst_n = 1'b0;
        #1;
        check("lit_tmo_rst", 32'(mem_timeout), 0);
        tick();
        rst_n = 1'b1;
        tick();

        apply(0, 0, 0, 1); tick();
        for (int i = 0; i < 20; i++) begin apply(1, 0, 0, 0); tick(); end
        check("lit_bub_sat", 32'(bubble_count), SAT);
        apply(1, 0, 0, 1); tick();
        check("lit_clr_wins", 32'(bubble_count), 0);

        apply(0, 0, 1, 0); tick();
        apply(0, 1, 1, 0); tick();
        rst_n = 1'b0;
        #2;
        check("lit_rst_wait_ctrl", 32'(ctrl), 32'(C_RST));
        tick();
        rst_n = 1'b1;
        apply(0, 0, 0, 0);
        check("lit_no_stale_flush", 32'(ctrl), 32'(C_IDLE));
        tick();
        check("lit_no_stale_cnt", 32'(flush_count), 0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
